sdram_init_cfg: RTL and testbench

Parametrised SDRAM power-up initialiser, the next-generation replacement for the fixed DE10-Lite init sequencer. It drives the SDRAM command bus from reset through power-up wait, precharge-all, a configurable number of auto-refreshes and a Mode Register Set, then reports completion. After completion it also supports a runtime mode-register reload (PALL + MRS, no power-up wait, no refreshes) so the controller can change CAS latency or burst settings. It sits between the SDRAM controller's top FSM and the pins; the controller muxes the command bus over to its own logic once `end_init` is high.

---
 rtl/sdram_init_cfg.sv | 207 ++++++++++++++++++++
 tb/tb_sdram_init_cfg.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_init_cfg.sv
// SDRAM power-up initialiser: power-up wait, precharge-all, N auto-refreshes and MRS,
// then a runtime PALL+MRS reload path for changing the mode word after init.
module sdram_init_cfg #(
    parameter int          ADDR_WIDTH      = 13,
    parameter int          BA_WIDTH        = 2,
    parameter int          POWER_UP_CYCLES = 20000,
    parameter int          TRP_CYCLES      = 3,
    parameter int          TRC_CYCLES      = 9,
    parameter int          TMRD_CYCLES     = 2,
    parameter int          REFRESH_COUNT   = 8,
    parameter logic [2:0]  CAS_LATENCY     = 3'd3,
    parameter logic        BURST_TYPE      = 1'b0,
    parameter logic [2:0]  BURST_LENGTH    = 3'd0,
    parameter logic        WRITE_BURST     = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  reload,
    input  logic [9:0]            reload_mode,
    output logic                  busy,
    output logic                  end_init,
    output logic                  dram_cke,
    output logic [ADDR_WIDTH-1:0] dram_addr,
    output logic [BA_WIDTH-1:0]   dram_ba,
    output logic                  dram_cs_n,
    output logic                  dram_ras_n,
    output logic                  dram_cas_n,
    output logic                  dram_we_n
);

    localparam int PU_W    = (POWER_UP_CYCLES > 1) ? $clog2(POWER_UP_CYCLES + 1) : 1;
    localparam int RF_W    = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT + 1) : 1;
    localparam int DLY_MAX = (TRP_CYCLES > TRC_CYCLES)
                           ? ((TRP_CYCLES > TMRD_CYCLES) ? TRP_CYCLES : TMRD_CYCLES)
                           : ((TRC_CYCLES > TMRD_CYCLES) ? TRC_CYCLES : TMRD_CYCLES);
    localparam int DL_W    = (DLY_MAX > 2) ? $clog2(DLY_MAX - 1) : 1;

    // Wait counters count down to zero, so each wait state is loaded with (spacing - 2).
    localparam logic [PU_W-1:0] PU_LOAD  = PU_W'(POWER_UP_CYCLES - 1);
    localparam logic [DL_W-1:0] RP_LOAD  = DL_W'((TRP_CYCLES  > 1) ? TRP_CYCLES  - 2 : 0);
    localparam logic [DL_W-1:0] RC_LOAD  = DL_W'((TRC_CYCLES  > 1) ? TRC_CYCLES  - 2 : 0);
    localparam logic [DL_W-1:0] MRD_LOAD = DL_W'((TMRD_CYCLES > 1) ? TMRD_CYCLES - 2 : 0);
    localparam logic [RF_W-1:0] REF_LAST = RF_W'(REFRESH_COUNT);

    localparam logic [9:0] MODE_DEFAULT = {WRITE_BURST, 2'b00, CAS_LATENCY, BURST_TYPE, BURST_LENGTH};

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PALL = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_POWER_UP,
        S_PALL,
        S_WAIT_RP,
        S_AREF,
        S_WAIT_RC,
        S_MRS,
        S_WAIT_MRD,
        S_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [PU_W-1:0]       pu_cnt, pu_cnt_nxt;
    logic [DL_W-1:0]       dly_cnt, dly_cnt_nxt;
    logic [RF_W-1:0]       ref_cnt, ref_cnt_nxt;
    logic [9:0]            mode_reg, mode_nxt;
    logic                  reload_flag, reload_flag_nxt;

    logic [3:0]            cmd_q, cmd_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [BA_WIDTH-1:0]   ba_q, ba_nxt;
    logic                  cke_q, cke_nxt;
    logic                  busy_q, busy_nxt;
    logic                  end_q, end_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            pu_cnt      <= '0;
            dly_cnt     <= '0;
            ref_cnt     <= '0;
            mode_reg    <= MODE_DEFAULT;
            reload_flag <= 1'b0;
            cmd_q       <= CMD_NOP;
            addr_q      <= '0;
            ba_q        <= '0;
            cke_q       <= 1'b0;
            busy_q      <= 1'b0;
            end_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            pu_cnt      <= pu_cnt_nxt;
            dly_cnt     <= dly_cnt_nxt;
            ref_cnt     <= ref_cnt_nxt;
            mode_reg    <= mode_nxt;
            reload_flag <= reload_flag_nxt;
            cmd_q       <= cmd_nxt;
            addr_q      <= addr_nxt;
            ba_q        <= ba_nxt;
            cke_q       <= cke_nxt;
            busy_q      <= busy_nxt;
            end_q       <= end_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pu_cnt_nxt      = pu_cnt;
        dly_cnt_nxt     = dly_cnt;
        ref_cnt_nxt     = ref_cnt;
        mode_nxt        = mode_reg;
        reload_flag_nxt = reload_flag;

        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nxt   = S_POWER_UP;
                    pu_cnt_nxt  = PU_LOAD;
                    ref_cnt_nxt = '0;
                end
            end
            S_POWER_UP: begin
                if (pu_cnt == '0) state_nxt = S_PALL;
                else              pu_cnt_nxt = pu_cnt - 1'b1;
            end
            // A spacing of one cycle skips the wait state entirely.
            S_PALL: begin
                if (TRP_CYCLES > 1) begin
                    state_nxt   = S_WAIT_RP;
                    dly_cnt_nxt = RP_LOAD;
                end else begin
                    state_nxt = reload_flag ? S_MRS : S_AREF;
                end
            end
            S_WAIT_RP: begin
                if (dly_cnt == '0) state_nxt = reload_flag ? S_MRS : S_AREF;
                else               dly_cnt_nxt = dly_cnt - 1'b1;
            end
            S_AREF: begin
                ref_cnt_nxt = ref_cnt + 1'b1;
                if (TRC_CYCLES > 1) begin
                    state_nxt   = S_WAIT_RC;
                    dly_cnt_nxt = RC_LOAD;
                end else begin
                    state_nxt = (ref_cnt_nxt == REF_LAST) ? S_MRS : S_AREF;
                end
            end
            S_WAIT_RC: begin
                if (dly_cnt == '0) state_nxt = (ref_cnt == REF_LAST) ? S_MRS : S_AREF;
                else               dly_cnt_nxt = dly_cnt - 1'b1;
            end
            S_MRS: begin
                if (TMRD_CYCLES > 1) begin
                    state_nxt   = S_WAIT_MRD;
                    dly_cnt_nxt = MRD_LOAD;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_WAIT_MRD: begin
                if (dly_cnt == '0) state_nxt = S_DONE;
                else               dly_cnt_nxt = dly_cnt - 1'b1;
            end
            S_DONE: begin
                if (reload) begin
                    state_nxt       = S_PALL;
                    mode_nxt        = reload_mode;
                    reload_flag_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (state_nxt == S_DONE) reload_flag_nxt = 1'b0;

        // Outputs are decoded from the next state so the pins change on the same edge as the state.
        cmd_nxt  = CMD_NOP;
        addr_nxt = '0;
        ba_nxt   = '0;
        cke_nxt  = (state_nxt != S_IDLE);
        busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
        end_nxt  = (state_nxt == S_DONE);
        case (state_nxt)
            S_PALL: begin
                cmd_nxt      = CMD_PALL;
                addr_nxt[10] = 1'b1;
            end
            S_AREF:  cmd_nxt = CMD_AREF;
            S_MRS: begin
                cmd_nxt       = CMD_MRS;
                addr_nxt[9:0] = mode_nxt;
            end
            default: cmd_nxt = CMD_NOP;
        endcase
    end

    assign {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = cmd_q;
    assign dram_addr = addr_q;
    assign dram_ba   = ba_q;
    assign dram_cke  = cke_q;
    assign busy      = busy_q;
    assign end_init  = end_q;

endmodule

// File: tb/tb_sdram_init_cfg.sv
// Bench for sdram_init_cfg: a schedule-based model checked every cycle on a default
// and a parameter-override instance, plus literal command-timing expectations.
module tb_sdram_init_cfg;

    typedef struct packed {
        int         pu;
        int         trp;
        int         trc;
        int         tmrd;
        int         rc;
        logic [9:0] defw;
    } cfg_t;

    // phase: 0 idle, 1 init sequence, 2 done, 3 reload sequence; t0 is the accepting cycle.
    typedef struct packed {
        int         phase;
        int         t0;
        logic [9:0] word;
    } mst_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic [1:0]  ba;
        logic        cke;
        logic        busy;
        logic        endi;
    } exp_t;

    typedef struct packed {
        int          cyc;
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic [1:0]  ba;
    } ev_t;

    typedef struct packed {
        int          n_pall;
        int          n_aref;
        int          n_mrs;
        int          pall_c;
        int          aref_first;
        int          aref_last;
        int          mrs_c;
        logic [12:0] pall_addr;
        logic [12:0] mrs_addr;
        logic [1:0]  mrs_ba;
    } sum_t;

    localparam cfg_t CFG_A = '{pu: 20000, trp: 3, trc: 9, tmrd: 2, rc: 8, defw: 10'h230};
    localparam cfg_t CFG_B = '{pu: 10,    trp: 1, trc: 2, tmrd: 1, rc: 2, defw: 10'h220};
    localparam exp_t RESET_BUS = {4'b0111, 18'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, rl_a;
    logic [9:0] rm_a;
    logic       rst_b, en_b, rl_b;
    logic [9:0] rm_b;

    logic        a_busy, a_end, a_cke, a_cs, a_ras, a_cas, a_we;
    logic [12:0] a_addr;
    logic [1:0]  a_ba;
    logic        b_busy, b_end, b_cke, b_cs, b_ras, b_cas, b_we;
    logic [12:0] b_addr;
    logic [1:0]  b_ba;

    sdram_init_cfg dut_a (
        .clock(clk), .reset(rst_a), .enable(en_a), .reload(rl_a), .reload_mode(rm_a),
        .busy(a_busy), .end_init(a_end), .dram_cke(a_cke), .dram_addr(a_addr), .dram_ba(a_ba),
        .dram_cs_n(a_cs), .dram_ras_n(a_ras), .dram_cas_n(a_cas), .dram_we_n(a_we)
    );

    sdram_init_cfg #(
        .POWER_UP_CYCLES(10), .TRP_CYCLES(1), .TRC_CYCLES(2), .TMRD_CYCLES(1),
        .REFRESH_COUNT(2), .CAS_LATENCY(3'd2)
    ) dut_b (
        .clock(clk), .reset(rst_b), .enable(en_b), .reload(rl_b), .reload_mode(rm_b),
        .busy(b_busy), .end_init(b_end), .dram_cke(b_cke), .dram_addr(b_addr), .dram_ba(b_ba),
        .dram_cs_n(b_cs), .dram_ras_n(b_ras), .dram_cas_n(b_cas), .dram_we_n(b_we)
    );

    exp_t bus_a, bus_b;
    assign bus_a = {a_cs, a_ras, a_cas, a_we, a_addr, a_ba, a_cke, a_busy, a_end};
    assign bus_b = {b_cs, b_ras, b_cas, b_we, b_addr, b_ba, b_cke, b_busy, b_end};

    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;
    mst_t ma, mb;
    ev_t  ev_a[$];
    ev_t  ev_b[$];
    int   a_rise = -1;
    int   b_rise = -1;
    logic a_end_prev = 1'b0;
    logic b_end_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int init_len(input cfg_t c);
        return c.pu + 1 + c.trp + c.trc * c.rc + c.tmrd;
    endfunction

    function automatic mst_t model_step(input cfg_t c, input mst_t s, input logic rst,
                                        input logic en, input logic rl, input logic [9:0] rm,
                                        input int old);
        mst_t n = s;
        int   ncyc = old + 1;
        if (rst) begin
            n.phase = 0;
            n.t0    = 0;
            n.word  = c.defw;
        end else begin
            case (s.phase)
                0: if (en) begin n.phase = 1; n.t0 = old; end
                1: if (ncyc - s.t0 == init_len(c)) n.phase = 2;
                2: if (rl) begin n.phase = 3; n.t0 = old; n.word = rm; end
                3: if (ncyc - s.t0 == 1 + c.trp + c.tmrd) n.phase = 2;
                default: n.phase = 0;
            endcase
        end
        return n;
    endfunction

    function automatic exp_t model_out(input cfg_t c, input mst_t s, input int now);
        exp_t e;
        int   d    = now - s.t0;
        int   base = c.pu + 1 + c.trp;
        e.cmd  = 4'b0111;
        e.addr = '0;
        e.ba   = '0;
        e.cke  = (s.phase != 0);
        e.busy = (s.phase == 1) || (s.phase == 3);
        e.endi = (s.phase == 2);
        if (s.phase == 1) begin
            if (d == c.pu + 1) begin
                e.cmd  = 4'b0010;
                e.addr = 13'h0400;
            end else if (d >= base && (d - base) % c.trc == 0 && (d - base) / c.trc < c.rc) begin
                e.cmd = 4'b0001;
            end else if (d == base + c.trc * c.rc) begin
                e.cmd  = 4'b0000;
                e.addr = {3'b000, s.word};
            end
        end else if (s.phase == 3) begin
            if (d == 1) begin
                e.cmd  = 4'b0010;
                e.addr = 13'h0400;
            end else if (d == 1 + c.trp) begin
                e.cmd  = 4'b0000;
                e.addr = {3'b000, s.word};
            end
        end
        return e;
    endfunction

    function automatic sum_t summarize(input ev_t q[$]);
        sum_t sm;
        sm.n_pall = 0; sm.n_aref = 0; sm.n_mrs = 0;
        sm.pall_c = -1; sm.aref_first = -1; sm.aref_last = -1; sm.mrs_c = -1;
        sm.pall_addr = '0; sm.mrs_addr = '0; sm.mrs_ba = '0;
        foreach (q[i]) begin
            case (q[i].cmd)
                4'b0010: begin
                    sm.n_pall++;
                    if (sm.pall_c < 0) begin sm.pall_c = q[i].cyc; sm.pall_addr = q[i].addr; end
                end
                4'b0001: begin
                    sm.n_aref++;
                    if (sm.aref_first < 0) sm.aref_first = q[i].cyc;
                    sm.aref_last = q[i].cyc;
                end
                4'b0000: begin
                    sm.n_mrs++;
                    sm.mrs_c = q[i].cyc; sm.mrs_addr = q[i].addr; sm.mrs_ba = q[i].ba;
                end
                default: ;
            endcase
        end
        return sm;
    endfunction

    always @(posedge clk) begin
        ma  <= model_step(CFG_A, ma, rst_a, en_a, rl_a, rm_a, cyc);
        mb  <= model_step(CFG_B, mb, rst_b, en_b, rl_b, rm_b, cyc);
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("A_bus", bus_a, model_out(CFG_A, ma, cyc));
            chk("B_bus", bus_b, model_out(CFG_B, mb, cyc));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (bus_a.cmd != 4'b0111) ev_a.push_back('{cyc: cyc, cmd: bus_a.cmd, addr: a_addr, ba: a_ba});
            if (bus_b.cmd != 4'b0111) ev_b.push_back('{cyc: cyc, cmd: bus_b.cmd, addr: b_addr, ba: b_ba});
            if (a_end && !a_end_prev) a_rise <= cyc;
            if (b_end && !b_end_prev) b_rise <= cyc;
        end
        a_end_prev <= a_end;
        b_end_prev <= b_end;
    end

    task automatic wait_end_a(input int budget);
        int n = 0;
        while (a_end !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("A_end_timeout", {31'b0, a_end}, 32'd1);
    endtask

    task automatic check_full_run(input string tag, input int s);
        sum_t sm = summarize(ev_a);
        chk({tag, "_pall_cycle"}, sm.pall_c - s, 20001);
        chk({tag, "_pall_addr"}, {19'b0, sm.pall_addr}, 32'h0400);
        chk({tag, "_aref_count"}, sm.n_aref, 8);
        chk({tag, "_aref_first"}, sm.aref_first - s, 20004);
        chk({tag, "_aref_last"}, sm.aref_last - s, 20067);
        chk({tag, "_mrs_cycle"}, sm.mrs_c - s, 20076);
        chk({tag, "_mrs_addr"}, {19'b0, sm.mrs_addr}, 32'h0230);
        chk({tag, "_mrs_ba"}, {30'b0, sm.mrs_ba}, 32'd0);
        chk({tag, "_end_rise"}, a_rise - s, 20078);
    endtask

    initial begin
        int   e0, e1, e2, r;
        sum_t sm;
        rst_a = 1'b1; en_a = 1'b0; rl_a = 1'b0; rm_a = 10'h000;
        rst_b = 1'b1; en_b = 1'b0; rl_b = 1'b0; rm_b = 10'h000;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("A_reset_bus", bus_a, RESET_BUS);
        chk("B_reset_bus", bus_b, RESET_BUS);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) @(negedge clk);

        // Default run with stray reload in POWER_UP and stray enable in WAIT_RC.
        ev_a.delete(); ev_b.delete();
        e0 = cyc;
        en_a = 1'b1; en_b = 1'b1;
        @(negedge clk);
        en_a = 1'b0; en_b = 1'b0;
        chk("A_cke_cycle1", {31'b0, a_cke}, 32'd1);
        repeat (99) @(negedge clk);
        rl_a = 1'b1; rm_a = 10'h3FF;
        @(negedge clk);
        rl_a = 1'b0;
        while (cyc < e0 + 20006) @(negedge clk);
        en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        wait_end_a(500);
        repeat (3) @(negedge clk);
        check_full_run("A_run1", e0);

        sm = summarize(ev_b);
        chk("B_pall_cycle", sm.pall_c - e0, 11);
        chk("B_aref_count", sm.n_aref, 2);
        chk("B_aref_first", sm.aref_first - e0, 12);
        chk("B_aref_last", sm.aref_last - e0, 14);
        chk("B_mrs_cycle", sm.mrs_c - e0, 16);
        chk("B_mrs_addr", {19'b0, sm.mrs_addr}, 32'h0220);
        chk("B_end_rise", b_rise - e0, 17);

        en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        repeat (3) @(negedge clk);

        // Mode reload from DONE.
        ev_a.delete();
        r = cyc;
        rl_a = 1'b1; rm_a = 10'h020;
        @(negedge clk);
        rl_a = 1'b0; rm_a = 10'h3FF;
        chk("R_end_low", {31'b0, a_end}, 32'd0);
        repeat (10) @(negedge clk);
        sm = summarize(ev_a);
        chk("R_pall_cycle", sm.pall_c - r, 1);
        chk("R_mrs_cycle", sm.mrs_c - r, 4);
        chk("R_mrs_addr", {19'b0, sm.mrs_addr}, 32'h0020);
        chk("R_aref_count", sm.n_aref, 0);
        chk("R_end_rise", a_rise - r, 6);

        // Reset during the 4th WAIT_RC, then a full replay.
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        ev_a.delete();
        e1 = cyc;
        en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        while (cyc < e1 + 20035) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        chk("X_reset_bus", bus_a, RESET_BUS);
        sm = summarize(ev_a);
        chk("X_aref_count", sm.n_aref, 4);
        @(negedge clk);
        chk("X_idle_cke", {31'b0, a_cke}, 32'd0);
        ev_a.delete();
        e2 = cyc;
        en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        wait_end_a(21000);
        repeat (3) @(negedge clk);
        check_full_run("A_run2", e2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
